comparator_bist: RTL and testbench

COMPARATOR_BIST -- requirements
Module: comparator_bist

---
 rtl/comparator_bist.sv | 147 ++++++++++++++
 tb/tb_comparator_bist.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_bist.sv
// Built-in self test for a WIDTH-bit magnitude comparator.
// Sweeps every operand pair and tallies mismatching eq/gre/less responses.
module comparator_bist #(
   parameter int WIDTH  = 1,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] cmp_a,
   output logic [WIDTH-1:0] cmp_b,
   input  logic             cmp_eq,
   input  logic             cmp_gre,
   input  logic             cmp_less,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [7:0]       err_count,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b
);

   localparam int IW = 2 * WIDTH;
   localparam logic [IW-1:0] IDX_MAX = '1;
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      FINISH
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [IW-1:0] idx;
   logic [3:0]    settle_cnt;
   logic          first_fail;

   logic [2:0]    expected;
   logic [2:0]    response;
   logic          pair_fail;
   logic          settle_end;
   logic          idx_last;
   logic          launch;
   logic [7:0]    err_nx;

   // Operands are slices of the registered index, so they are glitch free.
   assign cmp_a = idx[IW-1:WIDTH];
   assign cmp_b = idx[WIDTH-1:0];

   always_comb begin
      expected   = {cmp_a == cmp_b, cmp_a > cmp_b, cmp_a < cmp_b};
      response   = {cmp_eq, cmp_gre, cmp_less};
      pair_fail  = (response != expected);
      settle_end = (settle_cnt == SETTLE_LAST);
      idx_last   = (idx == IDX_MAX);
      launch     = start && ((state == IDLE) || (state == FINISH));
      err_nx     = err_count;
      if (pair_fail && (err_count != 8'hFF))
         err_nx = err_count + 8'd1;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (launch)
               state_nx = DRIVE;
         end
         DRIVE: begin
            if (settle_end)
               state_nx = SAMPLE;
         end
         SAMPLE: begin
            if (idx_last)
               state_nx = FINISH;
            else
               state_nx = DRIVE;
         end
         FINISH: begin
            if (launch)
               state_nx = DRIVE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         settle_cnt <= '0;
         first_fail <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_a     <= '0;
         fail_b     <= '0;
      end else if (launch) begin
         idx        <= '0;
         settle_cnt <= '0;
         first_fail <= 1'b0;
         busy       <= 1'b1;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_a     <= '0;
         fail_b     <= '0;
      end else begin
         unique case (state)
            DRIVE: begin
               if (settle_end)
                  settle_cnt <= '0;
               else
                  settle_cnt <= settle_cnt + 4'd1;
            end
            SAMPLE: begin
               err_count <= err_nx;
               if (pair_fail && !first_fail) begin
                  first_fail <= 1'b1;
                  fail_a     <= cmp_a;
                  fail_b     <= cmp_b;
               end
               // Pass is judged on the count including the final pair.
               if (idx_last) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                  pass <= (err_nx == 8'd0);
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comparator_bist.sv
// Directed bench for comparator_bist with behavioural comparators
// that can be faulted; pair order and final results are scoreboarded.
module tb_comparator_bist;

   logic clk;
   logic rst;
   logic start1, start2, start4;
   int   mode1, mode2, mode4;
   int   vectors;
   int   miscompares;

   logic [0:0] a1, b1, fa1, fb1;
   logic [1:0] a2, b2, fa2, fb2;
   logic [3:0] a4, b4, fa4, fb4;
   logic       eq1, gre1, less1, busy1, done1, pass1;
   logic       eq2, gre2, less2, busy2, done2, pass2;
   logic       eq4, gre4, less4, busy4, done4, pass4;
   logic [7:0] err1, err2, err4;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       pass;
      logic [7:0] err;
      logic [3:0] fa;
      logic [3:0] fb;
      logic [3:0] ca;
      logic [3:0] cb;
   } snap_t;

   typedef struct {
      int cyc;
      int err;
      int fa;
      int fb;
      int pass;
   } end_t;

   int   q_pair[$];
   end_t q_end[$];

   comparator_bist #(.WIDTH(1), .SETTLE(1)) u_d1 (
      .clk(clk), .rst(rst), .start(start1),
      .cmp_a(a1), .cmp_b(b1),
      .cmp_eq(eq1), .cmp_gre(gre1), .cmp_less(less1),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_a(fa1), .fail_b(fb1)
   );

   comparator_bist #(.WIDTH(2), .SETTLE(3)) u_d2 (
      .clk(clk), .rst(rst), .start(start2),
      .cmp_a(a2), .cmp_b(b2),
      .cmp_eq(eq2), .cmp_gre(gre2), .cmp_less(less2),
      .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .fail_a(fa2), .fail_b(fb2)
   );

   comparator_bist #(.WIDTH(4), .SETTLE(1)) u_d4 (
      .clk(clk), .rst(rst), .start(start4),
      .cmp_a(a4), .cmp_b(b4),
      .cmp_eq(eq4), .cmp_gre(gre4), .cmp_less(less4),
      .busy(busy4), .done(done4), .pass(pass4),
      .err_count(err4), .fail_a(fa4), .fail_b(fb4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // mode 0 good, 1 gre stuck at 0, 2 all zero, 3 all one
   function automatic logic [2:0] model_resp(int mode, logic [3:0] a,
                                             logic [3:0] b);
      logic [2:0] r;
      r = {a == b, a > b, a < b};
      case (mode)
         1: r[1] = 1'b0;
         2: r = 3'b000;
         3: r = 3'b111;
         default: ;
      endcase
      return r;
   endfunction

   always_comb {eq1, gre1, less1} = model_resp(mode1, 4'(a1), 4'(b1));
   always_comb {eq2, gre2, less2} = model_resp(mode2, 4'(a2), 4'(b2));
   always_comb {eq4, gre4, less4} = model_resp(mode4, 4'(a4), 4'(b4));

   function automatic snap_t snap(int sel);
      snap_t s;
      case (sel)
         1: s = '{busy1, done1, pass1, err1,
                  4'(fa1), 4'(fb1), 4'(a1), 4'(b1)};
         2: s = '{busy2, done2, pass2, err2,
                  4'(fa2), 4'(fb2), 4'(a2), 4'(b2)};
         default: s = '{busy4, done4, pass4, err4, fa4, fb4, a4, b4};
      endcase
      return s;
   endfunction

   function automatic int get_mode(int sel);
      case (sel)
         1: return mode1;
         2: return mode2;
         default: return mode4;
      endcase
   endfunction

   task automatic set_start(int sel, logic v);
      case (sel)
         1: start1 = v;
         2: start2 = v;
         default: start4 = v;
      endcase
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset(int sel);
      snap_t s;
      s = snap(sel);
      check("rst_busy", 32'(s.busy), 0);
      check("rst_done", 32'(s.done), 0);
      check("rst_pass", 32'(s.pass), 0);
      check("rst_err", 32'(s.err), 0);
      check("rst_fail_a", 32'(s.fa), 0);
      check("rst_fail_b", 32'(s.fb), 0);
      check("rst_cmp_a", 32'(s.ca), 0);
      check("rst_cmp_b", 32'(s.cb), 0);
   endtask

   // Launch a sweep; optionally pulse start again at cycle 'extra'.
   task automatic run_sweep(int sel, int w, int s, int extra);
      int    n, per, k, mode, mask, e, first;
      int    exp_pair;
      end_t  x;
      snap_t sn;
      logic [3:0] a, b;
      n    = 1 << (2 * w);
      per  = s + 1;
      mask = (1 << w) - 1;
      mode = get_mode(sel);
      e = 0;
      first = 0;
      x = '{n * per, 0, 0, 0, 0};
      for (int i = 0; i < n; i++) begin
         a = 4'((i >> w) & mask);
         b = 4'(i & mask);
         q_pair.push_back(int'(a) * 16 + int'(b));
         if (model_resp(mode, a, b) != {a == b, a > b, a < b}) begin
            if (e < 255) e++;
            if (first == 0) begin
               first = 1;
               x.fa = int'(a);
               x.fb = int'(b);
            end
         end
      end
      x.err  = e;
      x.pass = (e == 0) ? 1 : 0;
      q_end.push_back(x);

      @(negedge clk);
      set_start(sel, 1'b1);
      @(negedge clk);
      set_start(sel, 1'b0);
      sn = snap(sel);
      check("launch_busy", 32'(sn.busy), 1);
      check("launch_done", 32'(sn.done), 0);
      check("launch_err", 32'(sn.err), 0);
      check("launch_fail_a", 32'(sn.fa), 0);
      k = 0;
      forever begin
         if ((k % per) == 0 && q_pair.size() > 0) begin
            exp_pair = q_pair.pop_front();
            sn = snap(sel);
            check("pair", 32'(int'(sn.ca) * 16 + int'(sn.cb)), exp_pair);
         end
         set_start(sel, (k == extra) ? 1'b1 : 1'b0);
         @(negedge clk);
         k++;
         sn = snap(sel);
         if (sn.done === 1'b1) break;
         if (k > n * per + 10) begin
            check("timeout", 32'(k), 32'(n * per));
            break;
         end
      end
      set_start(sel, 1'b0);
      x = q_end.pop_front();
      check("done_cycle", 32'(k), 32'(x.cyc));
      check("err_count", 32'(sn.err), 32'(x.err));
      check("fail_a", 32'(sn.fa), 32'(x.fa));
      check("fail_b", 32'(sn.fb), 32'(x.fb));
      check("pass", 32'(sn.pass), 32'(x.pass));
      check("busy_end", 32'(sn.busy), 0);
      check("pairs_left", 32'(q_pair.size()), 0);
   endtask

   task automatic check_hold(int sel, int err_exp);
      snap_t sn;
      repeat (3) begin
         @(negedge clk);
         sn = snap(sel);
         check("hold_done", 32'(sn.done), 1);
         check("hold_busy", 32'(sn.busy), 0);
         check("hold_err", 32'(sn.err), 32'(err_exp));
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      mode1 = 0;
      mode2 = 0;
      mode4 = 0;
      start1 = 1'b0;
      start2 = 1'b0;
      start4 = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_reset(1);
      check_reset(2);
      check_reset(4);

      run_sweep(1, 1, 1, -1);
      mode1 = 1;
      run_sweep(1, 1, 1, -1);
      check_hold(1, 1);
      mode1 = 0;
      run_sweep(1, 1, 1, 3);
      run_sweep(1, 1, 1, 7);
      check_hold(1, 0);

      mode2 = 2;
      run_sweep(2, 2, 3, -1);
      mode4 = 3;
      run_sweep(4, 4, 1, -1);
      check_hold(4, 255);

      mode1 = 1;
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset(1);
      check_reset(4);
      repeat (2) @(negedge clk);
      check_reset(1);
      mode1 = 0;
      run_sweep(1, 1, 1, -1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
